// File: rtl/mem_bus_arbiter.sv
// Shared external memory bus arbiter for DMA, CPU and debug-peek requesters.
// One-hot registered grants, dead cycles on every owner change, debug anti-starvation.
module mem_bus_arbiter #(
    parameter int TURNAROUND   = 1,
    parameter int STARVE_LIMIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dma_req,
    input  logic       dma_re,
    input  logic       dma_we,
    input  logic       cpu_req,
    input  logic       cpu_re,
    input  logic       cpu_we,
    input  logic       dbg_req,
    input  logic       dbg_re,
    input  logic       dbg_we,
    output logic       dma_gnt,
    output logic       cpu_gnt,
    output logic       dbg_gnt,
    output logic       cpu_mem_disable,
    output logic       bus_re,
    output logic       bus_we,
    output logic [1:0] owner,
    output logic       dbg_starved
);
    // state | meaning
    // OWN   | owner_q holds the bus, exactly one grant high
    // TURN  | dead cycles, all grants low, next_q is the pending owner
    localparam logic ST_OWN  = 1'b0;
    localparam logic ST_TURN = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_DMA  = 2'd1;
    localparam logic [1:0] OWN_CPU  = 2'd2;
    localparam logic [1:0] OWN_DBG  = 2'd3;

    logic       state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] next_q, next_d;
    logic [1:0] arb, tgt;
    logic [2:0] turn_q, turn_d;
    logic [7:0] starve_q;
    logic       rel;

    always_comb begin
        if (dma_req)                     arb = OWN_DMA;
        else if (dbg_req && dbg_starved) arb = OWN_DBG;
        else if (cpu_req)                arb = OWN_CPU;
        else if (dbg_req)                arb = OWN_DBG;
        else                             arb = OWN_CPU;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        next_d  = next_q;
        turn_d  = turn_q;
        rel     = 1'b0;
        tgt     = next_q;
        case (state_q)
            ST_OWN: begin
                // CPU is only released to DMA, or to debug when the CPU is idle
                if (owner_q == OWN_CPU) begin
                    if (dma_req) begin
                        rel = 1'b1;
                        tgt = OWN_DMA;
                    end else if (!cpu_req && dbg_req) begin
                        rel = 1'b1;
                        tgt = OWN_DBG;
                    end
                end else if (owner_q == OWN_DMA) begin
                    rel = !dma_req;
                    tgt = arb;
                end else begin
                    rel = !dbg_req;
                    tgt = arb;
                end
                if (rel) begin
                    state_d = ST_TURN;
                    owner_d = OWN_NONE;
                    next_d  = tgt;
                    turn_d  = 3'(TURNAROUND - 1);
                end
            end
            default: begin
                tgt    = dma_req ? OWN_DMA : next_q;
                next_d = tgt;
                if (turn_q == 3'd0) begin
                    state_d = ST_OWN;
                    owner_d = tgt;
                end else begin
                    turn_d = turn_q - 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_OWN;
            owner_q <= OWN_CPU;
            next_q  <= OWN_CPU;
            turn_q  <= 3'd0;
            dma_gnt <= 1'b0;
            cpu_gnt <= 1'b1;
            dbg_gnt <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            next_q  <= next_d;
            turn_q  <= turn_d;
            dma_gnt <= (owner_d == OWN_DMA);
            cpu_gnt <= (owner_d == OWN_CPU);
            dbg_gnt <= (owner_d == OWN_DBG);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_q <= 8'd0;
        end else if (dbg_gnt || !dbg_req) begin
            starve_q <= 8'd0;
        end else if (starve_q != 8'(STARVE_LIMIT)) begin
            starve_q <= starve_q + 8'd1;
        end
    end

    assign dbg_starved     = (starve_q == 8'(STARVE_LIMIT));
    assign owner           = owner_q;
    assign cpu_mem_disable = ~cpu_gnt;
    assign bus_re = (dma_gnt & dma_re) | (cpu_gnt & cpu_re) | (dbg_gnt & dbg_re);
    assign bus_we = (dma_gnt & dma_we) | (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, corner sequences,
// and random traffic against a behavioural ownership model (two parameterisations).
module tb_mem_bus_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic dma_req = 0, dma_re = 0, dma_we = 0;
    logic cpu_req = 0, cpu_re = 0, cpu_we = 0;
    logic dbg_req = 0, dbg_re = 0, dbg_we = 0;

    logic       dma_gnt_w [2];
    logic       cpu_gnt_w [2];
    logic       dbg_gnt_w [2];
    logic       cmd_w     [2];
    logic       bus_re_w  [2];
    logic       bus_we_w  [2];
    logic [1:0] owner_w   [2];
    logic       starved_w [2];

    mem_bus_arbiter #(.TURNAROUND(1), .STARVE_LIMIT(16)) dut (
        .clock(clock), .reset(reset),
        .dma_req(dma_req), .dma_re(dma_re), .dma_we(dma_we),
        .cpu_req(cpu_req), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .dbg_req(dbg_req), .dbg_re(dbg_re), .dbg_we(dbg_we),
        .dma_gnt(dma_gnt_w[0]), .cpu_gnt(cpu_gnt_w[0]), .dbg_gnt(dbg_gnt_w[0]),
        .cpu_mem_disable(cmd_w[0]), .bus_re(bus_re_w[0]), .bus_we(bus_we_w[0]),
        .owner(owner_w[0]), .dbg_starved(starved_w[0])
    );

    mem_bus_arbiter #(.TURNAROUND(3), .STARVE_LIMIT(4)) dut3 (
        .clock(clock), .reset(reset),
        .dma_req(dma_req), .dma_re(dma_re), .dma_we(dma_we),
        .cpu_req(cpu_req), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .dbg_req(dbg_req), .dbg_re(dbg_re), .dbg_we(dbg_we),
        .dma_gnt(dma_gnt_w[1]), .cpu_gnt(cpu_gnt_w[1]), .dbg_gnt(dbg_gnt_w[1]),
        .cpu_mem_disable(cmd_w[1]), .bus_re(bus_re_w[1]), .bus_we(bus_we_w[1]),
        .owner(owner_w[1]), .dbg_starved(starved_w[1])
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    int p_turn [2] = '{1, 3};
    int p_lim  [2] = '{16, 4};
    int m_owner [2];
    int m_left  [2];
    int m_next  [2];
    int m_wait  [2];

    typedef struct {
        logic [2:0] req;   // {dma, cpu, dbg}
        logic [2:0] re;
        logic [2:0] we;
        logic [1:0] exp_owner;
        logic       exp_re;
        logic       exp_we;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = 2;
            m_left[i]  = 0;
            m_next[i]  = 2;
            m_wait[i]  = 0;
        end
    endtask

    // Ownership model: owner 0 means dead time with m_left cycles remaining.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit starved, had_gnt, leave;
            int pick;
            starved = (m_wait[i] == p_lim[i]);
            had_gnt = (m_owner[i] == 3);
            if (m_owner[i] == 0) begin
                if (dma_req) m_next[i] = 1;
                if (m_left[i] == 1) m_owner[i] = m_next[i];
                else m_left[i] = m_left[i] - 1;
            end else begin
                leave = 0;
                pick  = 2;
                if (m_owner[i] == 2) begin
                    leave = dma_req || (!cpu_req && dbg_req);
                    pick  = dma_req ? 1 : 3;
                end else begin
                    leave = (m_owner[i] == 1) ? !dma_req : !dbg_req;
                    if (dma_req) pick = 1;
                    else if (dbg_req && starved) pick = 3;
                    else if (cpu_req) pick = 2;
                    else if (dbg_req) pick = 3;
                    else pick = 2;
                end
                if (leave) begin
                    m_owner[i] = 0;
                    m_left[i]  = p_turn[i];
                    m_next[i]  = pick;
                end
            end
            if (had_gnt || !dbg_req) m_wait[i] = 0;
            else if (m_wait[i] < p_lim[i]) m_wait[i] = m_wait[i] + 1;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic [2:0] req, input logic [2:0] re, input logic [2:0] we);
        {dma_req, cpu_req, dbg_req} = req;
        {dma_re, cpu_re, dbg_re}    = re;
        {dma_we, cpu_we, dbg_we}    = we;
    endtask

    task automatic do_reset();
        set_in(3'b000, 3'b000, 3'b000);
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic check_model(input int i);
        logic [2:0] eg;
        logic       er, ew;
        eg = {m_owner[i] == 1, m_owner[i] == 2, m_owner[i] == 3};
        er = (eg[2] & dma_re) | (eg[1] & cpu_re) | (eg[0] & dbg_re);
        ew = (eg[2] & dma_we) | (eg[1] & cpu_we) | (eg[0] & dbg_we);
        chk($sformatf("rnd%0d_owner", i), 8'(owner_w[i]), 8'(m_owner[i]));
        chk($sformatf("rnd%0d_gnt", i), 8'({dma_gnt_w[i], cpu_gnt_w[i], dbg_gnt_w[i]}), 8'(eg));
        chk($sformatf("rnd%0d_cmd", i), 8'(cmd_w[i]), 8'(!eg[1]));
        chk($sformatf("rnd%0d_re", i), 8'(bus_re_w[i]), 8'(er));
        chk($sformatf("rnd%0d_we", i), 8'(bus_we_w[i]), 8'(ew));
        chk($sformatf("rnd%0d_starved", i), 8'(starved_w[i]), 8'(m_wait[i] == p_lim[i]));
    endtask

    initial begin
        int dead, bad, got;

        vecs[0]  = '{3'b010, 3'b010, 3'b000, 2'd2, 1'b1, 1'b0};
        vecs[1]  = '{3'b110, 3'b100, 3'b000, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{3'b110, 3'b100, 3'b000, 2'd1, 1'b1, 1'b0};
        vecs[3]  = '{3'b101, 3'b001, 3'b000, 2'd1, 1'b0, 1'b0};
        vecs[4]  = '{3'b011, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0};
        vecs[5]  = '{3'b011, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0};
        vecs[6]  = '{3'b001, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0};
        vecs[7]  = '{3'b101, 3'b000, 3'b000, 2'd1, 1'b0, 1'b0};
        vecs[8]  = '{3'b001, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0};
        vecs[9]  = '{3'b001, 3'b000, 3'b001, 2'd3, 1'b0, 1'b1};
        vecs[10] = '{3'b000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0};
        vecs[11] = '{3'b000, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0};
        vecs[12] = '{3'b010, 3'b000, 3'b010, 2'd2, 1'b0, 1'b1};

        do_reset();
        chk("reset_owner", 8'(owner_w[0]), 8'd2);
        chk("reset_gnt", 8'({dma_gnt_w[0], cpu_gnt_w[0], dbg_gnt_w[0]}), 8'b010);
        chk("reset_cmd", 8'(cmd_w[0]), 8'd0);

        for (int v = 0; v < 13; v++) begin
            logic [2:0] eg;
            set_in(vecs[v].req, vecs[v].re, vecs[v].we);
            tick();
            eg = {vecs[v].exp_owner == 2'd1, vecs[v].exp_owner == 2'd2, vecs[v].exp_owner == 2'd3};
            chk($sformatf("vec%0d_owner", v), 8'(owner_w[0]), 8'(vecs[v].exp_owner));
            chk($sformatf("vec%0d_gnt", v), 8'({dma_gnt_w[0], cpu_gnt_w[0], dbg_gnt_w[0]}), 8'(eg));
            chk($sformatf("vec%0d_cmd", v), 8'(cmd_w[0]), 8'(!eg[1]));
            chk($sformatf("vec%0d_re", v), 8'(bus_re_w[0]), 8'(vecs[v].exp_re));
            chk($sformatf("vec%0d_we", v), 8'(bus_we_w[0]), 8'(vecs[v].exp_we));
        end

        // Debug starvation: CPU busy never yields to debug, even once starved
        do_reset();
        set_in(3'b011, 3'b000, 3'b000);
        repeat (15) tick();
        chk("starve_15", 8'(starved_w[0]), 8'd0);
        tick();
        chk("starve_16", 8'(starved_w[0]), 8'd1);
        bad = 0;
        repeat (10) begin
            tick();
            if (owner_w[0] != 2'd2) bad++;
        end
        chk("starve_cpu_kept", 8'(bad), 8'd0);
        cpu_req = 1'b0;
        tick();
        chk("starve_turn", 8'(owner_w[0]), 8'd0);
        tick();
        chk("starve_dbg_gnt", 8'(dbg_gnt_w[0]), 8'd1);
        tick();
        chk("starve_clear", 8'(starved_w[0]), 8'd0);

        // DBG owns; DMA waits for release with no CPU slot in between
        dma_req = 1'b1;
        repeat (3) tick();
        chk("dbg_hold", 8'(owner_w[0]), 8'd3);
        dbg_req = 1'b0;
        tick();
        chk("dbg_to_dma_turn", 8'(owner_w[0]), 8'd0);
        tick();
        chk("dbg_to_dma_gnt", 8'({dma_gnt_w[0], cpu_gnt_w[0], dbg_gnt_w[0]}), 8'b100);

        // Asynchronous reset in the middle of a DMA transfer
        #2 reset = 1'b0;
        #1;
        chk("mid_reset_gnt", 8'({dma_gnt_w[0], cpu_gnt_w[0], dbg_gnt_w[0]}), 8'b010);
        chk("mid_reset_owner", 8'(owner_w[0]), 8'd2);
        chk("mid_reset_cmd", 8'(cmd_w[0]), 8'd0);
        chk("mid_reset_starved", 8'(starved_w[0]), 8'd0);
        do_reset();

        // TURNAROUND=3 instance: exactly three silent dead cycles each way
        set_in(3'b100, 3'b111, 3'b111);
        dead = 0; bad = 0; got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            tick();
            if (owner_w[1] == 2'd1) got = 1;
            else if (owner_w[1] == 2'd0) begin
                dead++;
                if (bus_re_w[1] || bus_we_w[1]) bad++;
            end
        end
        chk("t3_dma_reached", 8'(got), 8'd1);
        chk("t3_dead_in", 8'(dead), 8'd3);
        chk("t3_quiet_in", 8'(bad), 8'd0);
        dma_req = 1'b0;
        dead = 0; bad = 0; got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            tick();
            if (owner_w[1] == 2'd2) got = 1;
            else if (owner_w[1] == 2'd0) begin
                dead++;
                if (bus_re_w[1] || bus_we_w[1]) bad++;
            end
        end
        chk("t3_cpu_reached", 8'(got), 8'd1);
        chk("t3_dead_out", 8'(dead), 8'd3);
        chk("t3_quiet_out", 8'(bad), 8'd0);

        // Random held-request traffic against the model, both instances
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) == 0) dma_req = ~dma_req;
            if ($urandom_range(0, 3) == 0) cpu_req = ~cpu_req;
            if ($urandom_range(0, 5) == 0) dbg_req = ~dbg_req;
            {dma_re, cpu_re, dbg_re} = 3'($urandom_range(0, 7));
            {dma_we, cpu_we, dbg_we} = 3'($urandom_range(0, 7));
            tick();
            check_model(0);
            check_model(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
